// File: rtl/kmeans_pkg.sv
// Shared definitions for the countdown sequencer: state encoding and default width.
package kmeans_pkg;

   localparam int DEFAULT_WIDTH = 6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // A sequence is in progress while issuing indices or while paused.
   function automatic logic isBusy(input state_e s);
      return (s == ST_RUN) || (s == ST_HOLD);
   endfunction

endpackage

// File: rtl/countdown_seq_if.sv
// Control and index-stream signals of the countdown sequencer.
// The master side requests sequences and accepts indices; the slave side is the sequencer.
interface countdown_seq_if import kmeans_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) ();

   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             enable;
   logic             idx_ready;
   logic [WIDTH-1:0] idx;
   logic             idx_valid;
   logic             busy;
   logic             done;

   modport master (
      output load, load_val, enable, idx_ready,
      input  idx, idx_valid, busy, done
   );

   modport slave (
      input  load, load_val, enable, idx_ready,
      output idx, idx_valid, busy, done
   );

endinterface

// File: rtl/countdown_seq.sv
// Countdown sequencer: on load it issues load_val, load_val-1, ... 0 as a
// valid/ready stream, can be paused with enable, then pulses done for one cycle.
// All outputs come straight from the state and index registers.
module countdown_seq import kmeans_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic            clk,
   input logic            rstn,
   countdown_seq_if.slave bus
);

   state_e           state_q;
   state_e           state_d;
   logic [WIDTH-1:0] idx_q;
   logic [WIDTH-1:0] idx_d;
   logic             idxValid;
   logic             transfer;
   logic             lastIdx;

   assign idxValid = (state_q == ST_RUN);
   assign transfer = idxValid & bus.idx_ready & bus.enable;
   assign lastIdx  = (idx_q == '0);

   // Next-state and next-index decision; load is only looked at in IDLE so a
   // running sequence can never be restarted, and index 0 ends the run instead
   // of wrapping to all-ones.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.load) begin
               idx_d   = bus.load_val;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!bus.enable) begin
               state_d = ST_HOLD;
            end else if (transfer) begin
               if (lastIdx) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q - WIDTH'(1);
               end
            end
         end
         ST_HOLD: begin
            if (bus.enable) begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and index registers; reset wins over every other input and aborts
   // any sequence without a done pulse.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   assign bus.idx       = idx_q;
   assign bus.idx_valid = idxValid;
   assign bus.busy      = isBusy(state_q);
   assign bus.done      = (state_q == ST_DONE);

endmodule

// File: doc/countdown_seq.md
COUNTDOWN_SEQ -- requirements
Module: countdown_seq

Interface
REQ-001 Parameter: WIDTH, default 6, count/index width in bits.
REQ-002 One clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  synchronous, active-high reset; name kept as in the codebase despite polarity.
REQ-005 load  input  1  start request; qualified with load_val.
REQ-006 load_val  input  WIDTH  start count; first index issued.
REQ-007 enable  input  1  advance permission; low = pause, count held.
REQ-008 idx_ready  input  1  downstream accepts idx this cycle.
REQ-009 idx  output  WIDTH  current index, registered.
REQ-010 idx_valid  output  1  idx is valid for transfer.
REQ-011 busy  output  1  high in RUN or HOLD.
REQ-012 done  output  1  single-cycle pulse after index 0 is transferred.

Function
REQ-013 FSM states: IDLE, RUN, HOLD, DONE; encoded 2 bits.
REQ-014 IDLE: load=1 -> idx<=load_val, go RUN next cycle; load=0 -> stay, idx held.
REQ-015 RUN: idx_valid=1; transfer = idx_valid & idx_ready & enable.
REQ-016 RUN, transfer, idx>0 -> idx<=idx-1, stay RUN; one index per cycle max.
REQ-017 RUN, transfer, idx==0 -> go DONE; idx stays 0; no wrap to all-ones.
REQ-018 RUN, enable=0 -> go HOLD; idx_valid=0 in HOLD; idx held.
REQ-019 HOLD, enable=1 -> back to RUN next cycle; no index skipped or repeated.
REQ-020 RUN, idx_ready=0 with enable=1 -> idx and idx_valid held (stall), stay RUN.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-022 load ignored in RUN, HOLD, DONE; no restart mid-sequence.
REQ-023 load_val=0 -> exactly one transfer (idx=0), then DONE.
REQ-024 load_val=2^WIDTH-1 -> 2^WIDTH transfers, descending, then DONE.
REQ-025 Decrement arithmetic is WIDTH bits unsigned; no carry out used.
REQ-026 busy, idx_valid, done decoded from state registers; no combinational input->output path.

Reset
REQ-027 rstn=1 at clk edge: state<=IDLE, idx<=0, idx_valid=0, busy=0, done=0.
REQ-028 rstn has priority over load, enable, idx_ready in every state.
REQ-029 rstn during RUN/HOLD aborts sequence; no done pulse issued.
REQ-030 First cycle after rstn deasserts: load accepted normally.

Structure
REQ-031 Shared package kmeans_pkg holds state enum type and default WIDTH constant.
REQ-032 Single module; no sub-modules; one state register plus one idx register.

Verification
REQ-033 load_val=5, enable=1, idx_ready=1 -> idx 5,4,3,2,1,0 on 6 consecutive cycles, done pulse next cycle, then IDLE.
REQ-034 load_val=3; enable low 2 cycles after first transfer -> idx held at 2, idx_valid=0, resumes 2,1,0 with no skip.
REQ-035 load_val=4; idx_ready low 3 cycles at idx=2 -> idx_valid stays 1, idx stays 2, then 1,0, done.
REQ-036 load_val=0 -> one transfer idx=0, done pulse, busy low afterward.
REQ-037 rstn=1 mid-RUN at idx=10 of load_val=20 -> next cycle idx=0, busy=0, done never asserts.
REQ-038 load=1 asserted during RUN with load_val=9 -> ignored; original sequence completes unchanged.
